// File: rtl/adc_sample_sequencer_if.sv
// AXI-Stream sample channel between the ADC sequencer FIFO
// and the register file's ADC FIFO data read port.
interface adc_sample_sequencer_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;

  modport master (
    output tdata,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    output tready
  );
endinterface

// File: rtl/adc_sample_sequencer.sv
// ADC conversion pacer (IDLE/WAIT/REQ/ACQ) with an 8-bit sample
// FIFO drained over AXI-Stream; sticky overflow/timeout flags.
module adc_sample_sequencer #(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     resn,
  input  logic                     start,
  input  logic                     soft_reset,
  input  logic [31:0]              waittime,
  output logic                     busy,
  output logic                     adc_req,
  input  logic [7:0]               adc_data,
  input  logic                     adc_valid,
  adc_sample_sequencer_if.master   m_axis,
  output logic                     fifo_empty,
  output logic                     fifo_full,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
  output logic                     timeout_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_REQ,
    S_ACQ
  } state_t;

  state_t        r_state;
  logic [31:0]   r_wcnt;
  logic [TW-1:0] r_acnt;
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [LW-1:0] r_level;
  logic          r_ovf;
  logic          r_to;

  logic          w_full;
  logic          w_acq_vld;
  logic          w_push;
  logic          w_pop;
  logic          w_acq_end;
  logic [31:0]   w_wload;

  assign w_full    = (r_level == LW'(DEPTH));
  assign w_acq_vld = (r_state == S_ACQ) && adc_valid;
  // full blocks the write even when a pop frees a slot this cycle
  assign w_push    = w_acq_vld && !w_full;
  assign w_pop     = (r_level != '0) && m_axis.tready;
  assign w_acq_end = w_acq_vld ||
                     ((r_state == S_ACQ) && (r_acnt == TW'(1)));
  assign w_wload   = (waittime == 32'd0) ? 32'd1 : waittime;

  always_ff @(posedge clk) begin
    if (!resn || soft_reset) begin
      r_state <= S_IDLE;
      r_wcnt  <= '0;
      r_acnt  <= '0;
      r_rd    <= '0;
      r_wr    <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
      r_to    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_WAIT;
            r_wcnt  <= w_wload;
          end
        end
        S_WAIT: begin
          r_wcnt <= r_wcnt - 32'd1;
          if (r_wcnt == 32'd1) begin
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          r_acnt  <= TW'(TIMEOUT);
          r_state <= S_ACQ;
        end
        S_ACQ: begin
          r_acnt <= r_acnt - TW'(1);
          if (w_acq_end) begin
            if (!adc_valid) begin
              r_to <= 1'b1;
            end
            if (start) begin
              r_state <= S_WAIT;
              r_wcnt  <= w_wload;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_acq_vld && w_full) begin
        r_ovf <= 1'b1;
      end
      if (w_push) begin
        r_mem[r_wr] <= adc_data;
        r_wr        <= r_wr + AW'(1);
      end
      if (w_pop) begin
        r_rd <= r_rd + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + LW'(1);
      end else if (w_pop && !w_push) begin
        r_level <= r_level - LW'(1);
      end
    end
  end

  assign busy          = (r_state != S_IDLE);
  assign adc_req       = (r_state == S_REQ);
  assign m_axis.tdata  = r_mem[r_rd];
  assign m_axis.tvalid = (r_level != '0);
  assign fifo_empty    = (r_level == '0);
  assign fifo_full     = w_full;
  assign fifo_level    = r_level;
  assign overflow      = r_ovf;
  assign timeout_err   = r_to;

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// Randomized bench for adc_sample_sequencer against a
// conversion-schedule and sample-queue reference model.
module tb_adc_sample_sequencer;

  localparam int DEPTH = 16;
  localparam int T     = 8;

  logic        clk = 1'b0;
  logic        resn;
  logic        start;
  logic        soft_reset;
  logic [31:0] waittime;
  logic        busy;
  logic        adc_req;
  logic [7:0]  adc_data;
  logic        adc_valid;
  logic        fifo_empty;
  logic        fifo_full;
  logic [4:0]  fifo_level;
  logic        overflow;
  logic        timeout_err;

  adc_sample_sequencer_if axis ();

  always #5 clk = ~clk;

  adc_sample_sequencer #(
    .DEPTH   (DEPTH),
    .TIMEOUT (T)
  ) dut (
    .clk         (clk),
    .resn        (resn),
    .start       (start),
    .soft_reset  (soft_reset),
    .waittime    (waittime),
    .busy        (busy),
    .adc_req     (adc_req),
    .adc_data    (adc_data),
    .adc_valid   (adc_valid),
    .m_axis      (axis),
    .fifo_empty  (fifo_empty),
    .fifo_full   (fifo_full),
    .fifo_level  (fifo_level),
    .overflow    (overflow),
    .timeout_err (timeout_err)
  );

  int errs   = 0;
  int checks = 0;
  int cyc    = 0;

  byte unsigned q[$];
  bit  m_ovf, m_to, m_active, m_zero;
  int  m_req   = -100;
  int  resp_at = -100;

  int  lat_lo = 1, lat_hi = 1;
  int  noresp_pct = 0, spur_pct = 0, rdy_pct = 0;
  bit  srst_arm = 0, rnd_data = 0, rnd_wait = 0;
  byte unsigned seq_val = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic sched(int req);
    if (int'($urandom_range(99)) < noresp_pct) begin
      resp_at = -100;
    end else begin
      resp_at = req + int'($urandom_range(lat_hi, lat_lo));
    end
  endtask

  // Conversion c: request at R, window R+1..R+T, next request
  // max(W,1)+1 cycles after the conversion ends if start is held.
  task automatic model_step(int c);
    int sz;
    bit in_acq, done, pop;
    if (!resn || soft_reset) begin
      q.delete();
      m_ovf = 0; m_to = 0; m_active = 0;
      m_req = -100; resp_at = -100; m_zero = 1;
      return;
    end
    sz     = q.size();
    pop    = (sz > 0) && axis.tready;
    in_acq = m_active && (c > m_req) && (c <= m_req + T);
    done   = 0;
    if (pop) void'(q.pop_front());
    if (in_acq && adc_valid) begin
      done = 1;
      if (sz == DEPTH) m_ovf = 1;
      else begin
        q.push_back(adc_data);
        m_zero = 0;
      end
    end else if (in_acq && c == m_req + T) begin
      done = 1;
      m_to = 1;
    end
    if (start && (done || !m_active)) begin
      m_active = 1;
      m_req = c + 1 + ((waittime == 0) ? 1 : int'(waittime));
      sched(m_req);
    end else if (done) begin
      m_active = 0;
    end
  endtask

  task automatic check_all();
    chk("busy", busy, m_active);
    chk("adc_req", adc_req, m_active && (cyc == m_req));
    chk("level", fifo_level, q.size());
    chk("empty", fifo_empty, q.size() == 0);
    chk("full", fifo_full, q.size() == DEPTH);
    chk("tvalid", axis.tvalid, q.size() != 0);
    chk("overflow", overflow, m_ovf);
    chk("timeout", timeout_err, m_to);
    if (q.size() > 0) chk("tdata", axis.tdata, q[0]);
    else if (m_zero) chk("tdata_rst", axis.tdata, 0);
  endtask

  task automatic step();
    adc_valid = (cyc == resp_at) ||
                (int'($urandom_range(99)) < spur_pct);
    adc_data  = rnd_data ? 8'($urandom) : seq_val;
    soft_reset = srst_arm && (cyc == resp_at);
    axis.tready = int'($urandom_range(99)) < rdy_pct;
    if (rnd_wait) waittime = $urandom_range(5);
    @(posedge clk);
    model_step(cyc);
    if (adc_valid) seq_val++;
    cyc++;
    #1;
    check_all();
  endtask

  initial begin
    resn = 0; start = 0; soft_reset = 0; waittime = 0;
    adc_valid = 0; adc_data = 0; axis.tready = 0;
    repeat (3) step();
    resn = 1;
    repeat (2) step();

    // single shot, W=16, L=3, sample 0x5A
    waittime = 16; lat_lo = 3; lat_hi = 3; seq_val = 8'h5A;
    start = 1; step(); start = 0;
    repeat (30) step();

    // continuous, W=4, L=2, samples 0..7 streamed out
    waittime = 4; lat_lo = 2; lat_hi = 2; seq_val = 0;
    rdy_pct = 100;
    start = 1; repeat (8 * 7) step(); start = 0;
    repeat (20) step();

    // overflow with consumer stalled
    rdy_pct = 0; waittime = 1; lat_lo = 1; lat_hi = 1;
    seq_val = 0;
    start = 1; repeat (3 * 18) step(); start = 0;
    repeat (10) step();
    rdy_pct = 100; repeat (11) step();

    // soft_reset in ACQ coinciding with adc_valid
    rdy_pct = 0; srst_arm = 1; waittime = 2;
    lat_lo = 2; lat_hi = 2;
    start = 1; step(); start = 0;
    repeat (10) step();
    srst_arm = 0;

    // timeout with a late adc_valid after the window
    waittime = 3; lat_lo = T + 2; lat_hi = T + 2;
    start = 1; step(); start = 0;
    repeat (25) step();

    // randomized traffic across pointer wrap
    rnd_data = 1; rnd_wait = 1; lat_lo = 1; lat_hi = 10;
    noresp_pct = 10; spur_pct = 5; rdy_pct = 50;
    for (int i = 0; i < 500; i++) begin
      start = (int'($urandom_range(99)) < 95);
      step();
    end
    start = 0; spur_pct = 0; rdy_pct = 100;
    repeat (40) step();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
